alu_iter: RTL and testbench

Parametrised, handshaked ALU for the npc datapath. It replaces the fixed 4-bit combinational ALU with a WIDTH-bit registered unit. The unit adds signed and unsigned compares, carry and error flags, and an optional iterative multiplier. It sits between operand fetch and writeback and uses valid/ready on both sides, so multi-cycle operations can stall the producer.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_iter.sv | 72 +++++++
 rtl/alu_iter.sv | 175 +++++++++++++++++
 tb/tb_alu_iter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the iterative ALU: opcodes, FSM encoding and default width.
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SEQ  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle for WIDTH cycles.
// product carries the final sum combinationally in the cycle done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_LAST);
  assign product  = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked WIDTH-bit ALU with registered result/flags; define ALU_MUL_EN
// to enable the iterative multiplier on opcode 9 (otherwise it is illegal).
//
// state  | meaning
// S_IDLE | no result held, ready for an operation
// S_BUSY | multiplier iterating, producer stalled
// S_DONE | result and flags held until out_ready
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf, op_carry, op_err, op_is_mul;

`ifdef ALU_MUL_EN
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;
  assign err       = err_q;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    op_res    = '0;
    op_ovf    = 1'b0;
    op_carry  = 1'b0;
    op_err    = 1'b0;
    op_is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        op_res   = sum[WIDTH-1:0];
        op_carry = sum[WIDTH];
        op_ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        op_res   = diff;
        op_carry = (a < b);
        op_ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_NOT:  op_res = ~a;
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_XOR:  op_res = a ^ b;
      OP_SLT:  op_res[0] = ($signed(a) < $signed(b));
      OP_SEQ:  op_res[0] = (a == b);
      OP_SLTU: op_res[0] = (a < b);
`ifdef ALU_MUL_EN
      OP_MUL:  op_is_mul = 1'b1;
`endif
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op_is_mul) begin
            state_d = S_BUSY;
`ifdef ALU_MUL_EN
            mul_start = 1'b1;
`endif
          end else begin
            state_d  = S_DONE;
            result_d = op_res;
            zero_d   = (op_res == '0);
            ovf_d    = op_ovf;
            carry_d  = op_carry;
            err_d    = op_err;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        if (mul_done) begin
          state_d  = S_DONE;
          result_d = mul_product[WIDTH-1:0];
          zero_d   = (mul_product[WIDTH-1:0] == '0);
          ovf_d    = |mul_product[2*WIDTH-1:WIDTH];
          carry_d  = 1'b0;
          err_d    = 1'b0;
        end else if (!mul_busy) begin
          // Multiplier lost its operation; drop back rather than stall forever.
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=8; covers both ALU_MUL_EN builds.
module tb_alu_iter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero, overflow, carry, err;

  // {out_valid, result, zero, overflow, carry, err}
  logic [12:0] obs;
  assign obs = {out_valid, result, zero, overflow, carry, err};

  int n_checks = 0;
  int n_fail = 0;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 9;
  localparam logic [12:0] EXP_MUL_A = {1'b1, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] EXP_MUL_B = {1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0};
`else
  localparam int MUL_LAT = 1;
  localparam logic [12:0] EXP_MUL_A = {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [12:0] EXP_MUL_B = {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

  alu_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Present one operation, let it be accepted, and return at the following negedge.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = '0; a = '0; b = '0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    issue(OP_ADD, 8'h7F, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_7f_01: got %h expected %h", obs, {1'b1, 8'h80, 4'b0100});
    end
  endtask

  task automatic test_sub();
    issue(OP_SUB, 8'h05, 8'h05);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_05_05: got %h expected %h", obs, {1'b1, 8'h00, 4'b1000});
    end
    issue(OP_SUB, 8'h03, 8'h05);
    n_checks++;
    if (obs !== {1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_03_05: got %h expected %h", obs, {1'b1, 8'hFE, 4'b0010});
    end
  endtask

  task automatic test_compare();
    issue(OP_SLT, 8'hFF, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL slt_ff_01: got %h expected %h", obs, {1'b1, 8'h01, 4'b0000});
    end
    issue(OP_SLTU, 8'hFF, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sltu_ff_01: got %h expected %h", obs, {1'b1, 8'h00, 4'b1000});
    end
    issue(OP_SEQ, 8'hFF, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL seq_ff_01: got %h expected %h", obs, {1'b1, 8'h00, 4'b1000});
    end
    issue(OP_NOT, 8'h3C, 8'h00);
    n_checks++;
    if (obs !== {1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL not_3c: got %h expected %h", obs, {1'b1, 8'hC3, 4'b0000});
    end
    issue(OP_OR, 8'h50, 8'h05);
    n_checks++;
    if (obs !== {1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL or_50_05: got %h expected %h", obs, {1'b1, 8'h55, 4'b0000});
    end
    issue(OP_ADD, 8'hFF, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_ff_01: got %h expected %h", obs, {1'b1, 8'h00, 4'b1010});
    end
  endtask

  task automatic test_illegal();
    issue(4'hF, 8'h12, 8'h34);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL illegal_op_f: got %h expected %h", obs, {1'b1, 8'h00, 4'b1001});
    end
  endtask

  task automatic test_mul(input logic [7:0] x, input logic [7:0] y, input logic [12:0] exp_obs);
    int cyc;
    bit ready_leak;
    cyc = 0;
    ready_leak = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = x; b = y; out_ready = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (!out_valid && in_ready) ready_leak = 1'b1;
      if (!out_valid) @(posedge clk);
    end while (!out_valid && cyc < 30);
    n_checks++;
    if (cyc != MUL_LAT) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected %0d", cyc, MUL_LAT);
    end
    n_checks++;
    if (ready_leak !== 1'b0) begin
      n_fail++; $display("FAIL mul_in_ready_low: got %b expected 0", ready_leak);
    end
    n_checks++;
    if (obs !== exp_obs) begin
      n_fail++; $display("FAIL mul_%0d_%0d: got %h expected %h", x, y, obs, exp_obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [12:0] ve [4];
    va = '{8'hA5, 8'hFF, 8'h12, 8'h80};
    vb = '{8'h5A, 8'hFF, 8'h34, 8'h01};
    ve = '{{1'b1, 8'hFF, 4'b0000}, {1'b1, 8'h00, 4'b1000},
           {1'b1, 8'h26, 4'b0000}, {1'b1, 8'h81, 4'b0000}};
    // Hold an AND result with out_ready low while junk is offered.
    @(negedge clk);
    in_valid = 1'b1; op = OP_AND; a = 8'hF0; b = 8'h3C; out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = OP_ADD; a = 8'hFF; b = 8'hFF;
      n_checks++;
      if ({obs, in_ready} !== {1'b1, 8'h30, 4'b0000, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h expected %h", i, {obs, in_ready}, {1'b1, 8'h30, 5'b00000});
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1; op = OP_XOR; a = va[0]; b = vb[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs !== ve[k]) begin
        n_fail++; $display("FAIL b2b_xor_%0d: got %h expected %h", k, obs, ve[k]);
      end
      if (k < 3) begin
        a = va[k+1]; b = vb[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_abort();
    bit stale;
    stale = 1'b0;
    issue(OP_ADD, 8'h40, 8'h02);
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 8'd13; b = 8'd11; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL abort_async_clear: got %h expected %h", obs, 13'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL abort_stale_result: got %b expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_illegal();
    test_mul(8'd13, 8'd11, EXP_MUL_A);
    test_mul(8'd20, 8'd20, EXP_MUL_B);
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
